pmu_ahb_master: RTL and testbench

//  AHB-Lite single-transfer initiator for accessing the PMU register file over AHB.

---
 rtl/pmu_ahb_master.sv | 199 +++++++++++++++++++
 tb/tb_pmu_ahb_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_ahb_master.sv
// Single-transfer AHB-Lite initiator for PMU register access; zero-wait slave gives accept->rsp in 3 cycles.
// One command outstanding: req_ready_o stays low until the response pulse, and the response cannot be stalled.
module pmu_ahb_master #(
  parameter int                     HADDR_WIDTH = 32,
  parameter int                     HDATA_WIDTH = 32,
  parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = 32'h80100000,
  parameter int                     N_REGS      = 47,
  parameter int                     TIMEOUT     = 16,
  localparam int                    IDX_W       = $clog2(N_REGS)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [IDX_W-1:0]       req_idx_i,
  input  logic [HDATA_WIDTH-1:0] req_wdata_i,
  output logic                   rsp_valid_o,
  output logic [HDATA_WIDTH-1:0] rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic                   hsel_o,
  output logic [HADDR_WIDTH-1:0] haddr_o,
  output logic                   hwrite_o,
  output logic [1:0]             htrans_o,
  output logic [2:0]             hsize_o,
  output logic [2:0]             hburst_o,
  output logic [3:0]             hprot_o,
  output logic                   hmastlock_o,
  output logic [HDATA_WIDTH-1:0] hwdata_o,
  input  logic                   hready_i,
  input  logic [1:0]             hresp_i,
  input  logic [HDATA_WIDTH-1:0] hrdata_i
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W:0]   N_REGS_L = (IDX_W + 1)'(N_REGS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  logic [1:0]             state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   write_q, write_d;
  logic [HDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                   bad_q, bad_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [HDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   hsel_q, hsel_d;
  logic [1:0]             htrans_q, htrans_d;
  logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                   hwrite_q, hwrite_d;
  logic [HDATA_WIDTH-1:0] hwdata_q, hwdata_d;

  logic                   done;
  logic                   done_err;
  logic [HDATA_WIDTH-1:0] done_rdata;

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    bad_d       = bad_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    hsel_d      = hsel_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    done        = 1'b0;
    done_err    = 1'b0;
    done_rdata  = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          ready_d  = 1'b0;
          write_d  = req_write_i;
          wdata_d  = req_wdata_i;
          sticky_d = 1'b0;
          cnt_d    = '0;
          if ({1'b0, req_idx_i} < N_REGS_L) begin
            bad_d    = 1'b0;
            state_d  = S_ADDR;
            hsel_d   = 1'b1;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = BASE_ADDR + HADDR_WIDTH'({req_idx_i, 2'b00});
            hwrite_d = req_write_i;
          end else begin
            // Out-of-range index spends one silent cycle in DATA so the error
            // answer lands two cycles after accept with the bus left idle.
            bad_d   = 1'b1;
            state_d = S_DATA;
          end
        end
      end
      S_ADDR: begin
        if (hready_i) begin
          state_d  = S_DATA;
          hsel_d   = 1'b0;
          htrans_d = HTRANS_IDLE;
          hwdata_d = write_q ? wdata_q : '0;
        end
      end
      S_DATA: begin
        if (bad_q) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (hready_i) begin
          done     = 1'b1;
          done_err = sticky_q | (hresp_i != HRESP_OKAY);
          if (!done_err && !write_q) done_rdata = hrdata_i;
        end else if (cnt_q == CNT_LAST) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (hresp_i != HRESP_OKAY) sticky_d = 1'b1;
        end
        if (done) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = done_err;
          rsp_rdata_d = done_rdata;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      bad_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      hsel_q      <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      bad_q       <= bad_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      hsel_q      <= hsel_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign hsel_o      = hsel_q;
  assign haddr_o     = haddr_q;
  assign hwrite_o    = hwrite_q;
  assign htrans_o    = htrans_q;
  assign hwdata_o    = hwdata_q;
  assign hsize_o     = 3'b010;
  assign hburst_o    = 3'b000;
  assign hprot_o     = 4'b0011;
  assign hmastlock_o = 1'b0;

endmodule

// File: tb/tb_pmu_ahb_master.sv
// Bench for pmu_ahb_master: scripted AHB slave plus random commands; responses scored by a queue-based monitor.
module tb_pmu_ahb_master;
  localparam int N_REGS  = 47;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [5:0]  req_idx_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        hsel_o;
  logic [31:0] haddr_o;
  logic        hwrite_o;
  logic [1:0]  htrans_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [3:0]  hprot_o;
  logic        hmastlock_o;
  logic [31:0] hwdata_o;
  logic        hready_i;
  logic [1:0]  hresp_i;
  logic [31:0] hrdata_i;

  pmu_ahb_master #(
    .HADDR_WIDTH(32), .HDATA_WIDTH(32), .BASE_ADDR(32'h80100000),
    .N_REGS(N_REGS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_idx_i(req_idx_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .hsel_o(hsel_o), .haddr_o(haddr_o), .hwrite_o(hwrite_o), .htrans_o(htrans_o),
    .hsize_o(hsize_o), .hburst_o(hburst_o), .hprot_o(hprot_o), .hmastlock_o(hmastlock_o),
    .hwdata_o(hwdata_o), .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
  );

  always #5 clk = ~clk;

  // Period numbering: the clock period ending at posedge N is period N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          period;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (period %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // mode: 0 = OKAY after w wait states, 1 = two-cycle ERROR, 2 = slave never ready
  function automatic exp_t model(input logic wr, input int idx, input logic [31:0] rd,
                                 input int aw, input int w, input int mode, input int acc);
    exp_t e;
    e.rdata = 32'h0;
    e.err   = 1'b1;
    if (idx >= N_REGS)  e.period = acc + 2;
    else if (mode == 2) e.period = acc + 2 + aw + TIMEOUT;
    else if (mode == 1) e.period = acc + 3 + aw + 1;
    else begin
      e.err    = 1'b0;
      e.rdata  = wr ? 32'h0 : rd;
      e.period = acc + 3 + aw + w;
    end
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid_o=1 expected no response (period %0d)", cyc + 1);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
          chk("rsp_period", 32'(cyc + 1), 32'(e.period));
        end
      end
    end
  end

  task automatic drive_garbage();
    req_valid_i = 1'($urandom_range(0, 1));
    req_write_i = 1'($urandom_range(0, 1));
    req_idx_i   = 6'($urandom);
    req_wdata_i = $urandom;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
    chk({tag, "_hsel"}, 32'(hsel_o), 32'd0);
    chk({tag, "_htrans"}, 32'(htrans_o), 32'd0);
    chk({tag, "_haddr"}, haddr_o, 32'd0);
    chk({tag, "_hwrite"}, 32'(hwrite_o), 32'd0);
    chk({tag, "_hwdata"}, hwdata_o, 32'd0);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      drive_garbage();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready_o=0 for 60 cycles expected 1");
    end
  endtask

  bit run_ok = 1'b1;

  task automatic run_txn(input logic wr, input int idx, input logic [31:0] data,
                         input int aw, input int w, input int mode, input bit rst_mid);
    bit          ok;
    int          acc;
    int          ndata;
    bit          last;
    logic [31:0] addr;
    wait_ready(ok);
    if (!ok) begin
      run_ok = 1'b0;
      return;
    end
    acc         = cyc + 1;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_idx_i   = 6'(idx);
    req_wdata_i = wr ? data : $urandom;
    hready_i    = 1'b1;
    hresp_i     = 2'b00;
    if (!rst_mid) exp_q.push_back(model(wr, idx, data, aw, w, mode, acc));
    if (idx >= N_REGS) begin
      @(negedge clk);
      drive_garbage();
      chk("bad_hsel", 32'(hsel_o), 32'd0);
      chk("bad_htrans", 32'(htrans_o), 32'd0);
    end else begin
      addr = 32'h80100000 + 32'(idx) * 4;
      for (int k = 0; k <= aw; k++) begin
        @(negedge clk);
        drive_garbage();
        hready_i = (k == aw);
        chk("addr_hsel", 32'(hsel_o), 32'd1);
        chk("addr_htrans", 32'(htrans_o), 32'b10);
        chk("addr_haddr", haddr_o, addr);
        chk("addr_hwrite", 32'(hwrite_o), 32'(wr));
        chk("addr_hsize", 32'(hsize_o), 32'b010);
      end
      ndata = (mode == 0) ? w + 1 : (mode == 1) ? 2 : TIMEOUT;
      for (int d = 0; d < ndata; d++) begin
        @(negedge clk);
        drive_garbage();
        last     = (d == ndata - 1);
        hready_i = (mode == 2) ? 1'b0 : last;
        hresp_i  = (mode == 1) ? 2'b01 : 2'b00;
        hrdata_i = (mode == 0 && last) ? data : $urandom;
        chk("data_hsel", 32'(hsel_o), 32'd0);
        chk("data_htrans", 32'(htrans_o), 32'd0);
        if (wr) chk("data_hwdata", hwdata_o, data);
        if (rst_mid && d == 1) begin
          #2 rstn_i = 1'b0;
          #1 reset_checks("midrst");
          @(negedge clk);
          reset_checks("midrst_hold");
          rstn_i      = 1'b1;
          req_valid_i = 1'b0;
          hready_i    = 1'b1;
          hresp_i     = 2'b00;
          return;
        end
      end
    end
    @(negedge clk);
    drive_garbage();
    hready_i = 1'b1;
    hresp_i  = 2'b00;
    hrdata_i = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int idx, mode, w, aw, gap;
    logic wr;
    rstn_i      = 1'b0;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_idx_i   = '0;
    req_wdata_i = '0;
    hready_i    = 1'b1;
    hresp_i     = 2'b00;
    hrdata_i    = '0;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    chk("const_hburst", 32'(hburst_o), 32'd0);
    chk("const_hprot", 32'(hprot_o), 32'b0011);
    chk("const_hmastlock", 32'(hmastlock_o), 32'd0);
    rstn_i = 1'b1;

    run_txn(1'b0, 3, 32'hCAFE0001, 0, 0, 0, 1'b0);
    run_txn(1'b1, 0, 32'h00000001, 0, 2, 0, 1'b0);
    run_txn(1'b0, 7, 32'h11111111, 0, 0, 1, 1'b0);
    run_txn(1'b0, 9, 32'h22222222, 0, 0, 2, 1'b0);
    run_txn(1'b0, 47, 32'h33333333, 0, 0, 0, 1'b0);
    run_txn(1'b0, 46, 32'h44444444, 0, TIMEOUT - 1, 0, 1'b0);
    run_txn(1'b1, 12, 32'hA5A5A5A5, 0, 5, 0, 1'b1);
    run_txn(1'b0, 3, 32'h12345678, 0, 0, 0, 1'b0);

    for (int n = 0; n < 150 && run_ok; n++) begin
      wr   = 1'($urandom_range(0, 1));
      idx  = ($urandom_range(0, 7) == 0) ? $urandom_range(N_REGS, 63) : $urandom_range(0, N_REGS - 1);
      aw   = $urandom_range(0, 1);
      mode = $urandom_range(0, 9);
      mode = (mode < 7) ? 0 : (mode < 9) ? 1 : 2;
      w    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(0, 3);
      run_txn(wr, idx, $urandom, aw, w, mode, 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        req_valid_i = 1'b0;
      end
    end

    req_valid_i = 1'b0;
    repeat (30) @(negedge clk);
    chk("pending_rsp", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
